// File: rtl/cla_sub_10bit_pipe.sv
// Two-stage pipelined carry-lookahead subtractor: computes i_min - i_sub as i_min + ~i_sub + 1,
// with the carry chain split at SPLIT bits across two valid/ready register stages.
module cla_sub_10bit_pipe #(
  parameter int WIDTH = 10,
  parameter int SPLIT = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_ovf
);

  localparam int HI_W = WIDTH - SPLIT;

  logic [WIDTH-1:0] b_full;
  logic [SPLIT-1:0] lo_g, lo_p, lo_diff;
  logic [SPLIT:0]   lo_c;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_diff_lo;
  logic             s1_carry;
  logic [HI_W-1:0]  s1_a_hi, s1_b_hi;
  logic             s1_sign_a, s1_sign_sub;

  logic [HI_W-1:0]  hi_g, hi_p, hi_diff;
  logic [HI_W:0]    hi_c;
  logic             ovf_next;

  logic s2_adv, s1_adv, accept;

  assign s2_adv  = !o_valid || i_ready;
  assign s1_adv  = !s1_valid || s2_adv;
  assign o_ready = s1_adv;
  assign accept  = i_valid && s1_adv;

  // Low slice: generate/propagate lookahead with the +1 of two's-complement negation as carry-in
  always_comb begin
    b_full  = ~i_sub;
    lo_g    = '0;
    lo_p    = '0;
    lo_diff = '0;
    lo_c    = '0;
    lo_c[0] = 1'b1;
    for (int i = 0; i < SPLIT; i++) begin
      lo_g[i]    = i_min[i] & b_full[i];
      lo_p[i]    = i_min[i] | b_full[i];
      lo_c[i+1]  = lo_g[i] | (lo_p[i] & lo_c[i]);
      lo_diff[i] = i_min[i] ^ b_full[i] ^ lo_c[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid    <= 1'b0;
      s1_diff_lo  <= '0;
      s1_carry    <= 1'b0;
      s1_a_hi     <= '0;
      s1_b_hi     <= '0;
      s1_sign_a   <= 1'b0;
      s1_sign_sub <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= i_valid;
      end
      if (accept) begin
        s1_diff_lo  <= lo_diff;
        s1_carry    <= lo_c[SPLIT];
        s1_a_hi     <= i_min[WIDTH-1:SPLIT];
        s1_b_hi     <= b_full[WIDTH-1:SPLIT];
        s1_sign_a   <= i_min[WIDTH-1];
        s1_sign_sub <= i_sub[WIDTH-1];
      end
    end
  end

  // High slice resumes the lookahead from the carry captured at the split point
  always_comb begin
    hi_g    = '0;
    hi_p    = '0;
    hi_diff = '0;
    hi_c    = '0;
    hi_c[0] = s1_carry;
    for (int i = 0; i < HI_W; i++) begin
      hi_g[i]    = s1_a_hi[i] & s1_b_hi[i];
      hi_p[i]    = s1_a_hi[i] | s1_b_hi[i];
      hi_c[i+1]  = hi_g[i] | (hi_p[i] & hi_c[i]);
      hi_diff[i] = s1_a_hi[i] ^ s1_b_hi[i] ^ hi_c[i];
    end
    ovf_next = (s1_sign_a != s1_sign_sub) && (hi_diff[HI_W-1] != s1_sign_a);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ovf    <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_result <= {~hi_c[HI_W], hi_diff, s1_diff_lo};
        o_ovf    <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_cla_sub_10bit_pipe.sv
// Self-checking bench for cla_sub_10bit_pipe: directed cases, backpressure, random streaming
// against an arithmetic reference model, and reset while the pipeline is full.
module tb_cla_sub_10bit_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [9:0]  i_min;
  logic [9:0]  i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [10:0] o_result;
  logic        o_ovf;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  cla_sub_10bit_pipe #(.WIDTH(10), .SPLIT(5)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_min    (i_min),
    .i_sub    (i_sub),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_ovf    (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, borrow, diff} from plain integer arithmetic
  function automatic logic [11:0] ref_model(input logic [9:0] a, input logic [9:0] b);
    int ua, ub, sa, sb, sd, d;
    logic borrow, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 512) ? ua - 1024 : ua;
    sb = (ub >= 512) ? ub - 1024 : ub;
    sd = sa - sb;
    d = (ua - ub + 1024) % 1024;
    borrow = (ua < ub);
    ovf = (sd > 511) || (sd < -512);
    return {ovf, borrow, d[9:0]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (o_valid !== 1'b0 || o_result !== 11'h0 || o_ovf !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_state: valid=%b result=%h ovf=%b ready=%b, required 0/000/0/1",
               o_valid, o_result, o_ovf, o_ready);
    end
  endtask

  task automatic test_directed();
    logic [9:0]  va[6] = '{10'd300, 10'd100, 10'd0, 10'd0, 10'h1FF, 10'h200};
    logic [9:0]  vb[6] = '{10'd100, 10'd300, 10'd1, 10'd0, 10'h3FF, 10'h001};
    logic [11:0] ve[6] = '{12'h0C8, 12'h738, 12'h7FF, 12'h000, 12'hE00, 12'h9FF};
    for (int k = 0; k < 6; k++) begin
      i_min   = va[k];
      i_sub   = vb[k];
      i_valid = 1'b1;
      i_ready = 1'b1;
      #1;
      total++;
      if (o_ready !== 1'b1) begin
        bad++;
        $display("[TB] FAIL directed_ready[%0d]: got %b required 1", k, o_ready);
      end
      next_cycle();
      i_valid = 1'b0;
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL directed_early[%0d]: o_valid=%b required 0", k, o_valid);
      end
      next_cycle();
      total++;
      if (o_valid !== 1'b1 || {o_ovf, o_result} !== ve[k]) begin
        bad++;
        $display("[TB] FAIL directed[%0d]: valid=%b got %h required %h", k, o_valid,
                 {o_ovf, o_result}, ve[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [9:0]  a[3];
    logic [9:0]  b[3];
    logic [11:0] e[3];
    for (int k = 0; k < 3; k++) begin
      a[k] = 10'($urandom);
      b[k] = 10'($urandom);
      e[k] = ref_model(a[k], b[k]);
    end
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_min = a[0]; i_sub = b[0];
    next_cycle();
    i_min = a[1]; i_sub = b[1];
    #1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_second_ready: got %b required 1", o_ready);
    end
    next_cycle();
    i_min = a[2]; i_sub = b[2];
    #1;
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || {o_ovf, o_result} !== e[0]) begin
      bad++;
      $display("[TB] FAIL bp_full: ready=%b valid=%b got %h required ready=0 valid=1 %h",
               o_ready, o_valid, {o_ovf, o_result}, e[0]);
    end
    next_cycle();
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1 || {o_ovf, o_result} !== e[0]) begin
      bad++;
      $display("[TB] FAIL bp_hold: ready=%b valid=%b got %h required ready=0 valid=1 %h",
               o_ready, o_valid, {o_ovf, o_result}, e[0]);
    end
    i_ready = 1'b1;
    #1;
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL bp_release_ready: got %b required 1", o_ready);
    end
    next_cycle();
    i_valid = 1'b0;
    for (int k = 1; k < 3; k++) begin
      total++;
      if (o_valid !== 1'b1 || {o_ovf, o_result} !== e[k]) begin
        bad++;
        $display("[TB] FAIL bp_drain[%0d]: valid=%b got %h required %h", k, o_valid,
                 {o_ovf, o_result}, e[k]);
      end
      next_cycle();
    end
    total++;
    if (o_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL bp_empty: o_valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_streaming();
    int sent = 0;
    int rcvd = 0;
    int cycles = 0;
    logic [11:0] exp;
    exp_q.delete();
    while (rcvd < 1000 && cycles < 20000) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      i_min   = 10'($urandom);
      i_sub   = 10'($urandom);
      #1;
      if (i_valid && o_ready) begin
        exp_q.push_back(ref_model(i_min, i_sub));
        sent++;
      end
      if (o_valid && exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL stream_spurious: o_valid=1 with nothing in flight, result=%h",
                 o_result);
      end else if (o_valid && i_ready) begin
        exp = exp_q.pop_front();
        total++;
        if ({o_ovf, o_result} !== exp) begin
          bad++;
          $display("[TB] FAIL stream[%0d]: got %h required %h", rcvd, {o_ovf, o_result}, exp);
        end
        rcvd++;
      end
      next_cycle();
      cycles++;
    end
    i_valid = 1'b0;
    total++;
    if (rcvd != 1000) begin
      bad++;
      $display("[TB] FAIL stream_timeout: received %0d required 1000", rcvd);
    end
  endtask

  task automatic test_reset_midflight();
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_min = 10'd7; i_sub = 10'd3;
    next_cycle();
    i_min = 10'd9; i_sub = 10'd1;
    next_cycle();
    i_valid = 1'b0;
    #1;
    total++;
    if (o_ready !== 1'b0 || o_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_fill: ready=%b valid=%b required 0/1", o_ready, o_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_result !== 11'h0 || o_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async: valid=%b result=%h ovf=%b required 0/000/0",
               o_valid, o_result, o_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_ready = 1'b1;
    next_cycle();
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_ready: got %b required 1", o_ready);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (o_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL rst_stale[%0d]: o_valid=%b required 0", k, o_valid);
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_min   = '0;
    i_sub   = '0;
    #11;
    test_reset();
    #11;
    rst_n = 1'b1;
    next_cycle();
    test_reset();
    test_directed();
    test_backpressure();
    test_streaming();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
